rr_grant_encoder: RTL and testbench
===================================

Name: rr_grant_encoder

Overview:
- 8-requester round-robin arbiter; emits the winning requester as a binary index plus a valid flag.
- Sits directly upstream of the 3-to-8 decoder stage. grant_idx drives the decoder select; grant_valid qualifies the decoder's one-hot output as a grant vector.
- Owns fairness rotation, grant hold and release, and a hold-timeout watchdog.

Parameters:
- N_REQ, 8, number of requesters; fixed at 8 to match the 3-bit decoder select.
- IDX_W, 3, width of grant_idx; must equal log2(N_REQ).
- MAX_HOLD, 15, maximum consecutive cycles a grant may be held; 0 disables the timeout.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  N_REQ  request lines; bit k is requester k; level-sensitive.
- release  input  1  current owner frees the grant; ignored while grant_valid=0.
- grant_valid  output  1  a grant is active.
- grant_idx  output  IDX_W  index of the current owner; valid only when grant_valid=1.
- timeout  output  1  one-cycle pulse when a grant is revoked by the watchdog.
- ptr  output  IDX_W  current round-robin search start (debug/observability).

Behaviour:
- All outputs are registered.
- Reset (rst=1 at a clk edge):
  - state=IDLE, grant_valid=0, grant_idx=0, ptr=0, timeout=0, hold_cnt=0.
  - Reset overrides every other input in the same cycle, including mid-grant; grant_valid is 0 after that edge.
- State IDLE:
  - Search req starting at bit ptr, ascending, wrapping 7->0. The first set bit wins.
  - If any req is set: next edge gives grant_valid=1, grant_idx=winner, hold_cnt=0, state=GRANT. Latency is 1 cycle from req sampled to grant.
  - If no req is set: remain in IDLE with outputs unchanged (grant_valid=0).
- State GRANT, end-of-grant condition: any of
  - release=1;
  - req[grant_idx]=0 (owner dropped its request);
  - MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 (watchdog).
- GRANT, no end condition: hold grant_idx, hold_cnt+=1; ptr unchanged.
- GRANT, end condition present:
  - ptr <= grant_idx+1 mod 8.
  - Search the remaining requests (req with bit grant_idx masked) starting at grant_idx+1, wrapping.
  - If a winner exists: direct handoff. Next edge: grant_valid stays 1, grant_idx=new winner, hold_cnt=0, remain in GRANT. No idle bubble.
  - If no winner: next edge grant_valid=0, state=IDLE; grant_idx keeps its last value.
- timeout is 1 for exactly the cycle after a watchdog-caused end condition.
  - If release or an owner drop coincides with the watchdog cycle, it counts as a normal release: timeout=0.
- Masking rule: the owner that just ended its grant cannot re-win in the same cycle, even if it is the only requester.
  - It may win again from IDLE one cycle later.
- hold_cnt: log2(MAX_HOLD+1) bits wide, saturating; never wraps.
- With MAX_HOLD=0, a grant persists indefinitely while req[grant_idx]=1 and release=0.
- release while grant_valid=0 has no effect.
- req changes on non-owner bits during GRANT do not affect the current grant.
- Invariant: grant_valid=1 implies req[grant_idx] was 1 at the edge that issued that grant.

Test Plan:
- Reset, then req=8'b0000_0100 -> one cycle later grant_valid=1, grant_idx=2; release=1 for one cycle with req=0 -> grant_valid=0 next cycle, ptr=3.
- req=8'hFF held, pulse release each grant cycle -> grant_idx sequence 0,1,2,...,7,0 with grant_valid continuously 1 (handoff, no bubble).
- ptr=6, req=8'b0100_0001 -> grant_idx=6; release -> grant_idx=0 (wrap); release -> grant_idx=6.
- MAX_HOLD=15, req=8'b0000_1000 held, no release -> grant_valid high for exactly 15 cycles, timeout pulses 1 cycle, then grant_valid=0 for 1 cycle, then grant_idx=3 again.
- Owner 5 drops req[5] mid-grant while req[1]=1 -> next cycle grant_idx=1, timeout=0; watchdog coinciding with release -> timeout=0.
- Assert rst during an active grant of idx 4 -> next cycle grant_valid=0, ptr=0, timeout=0; deassert rst with req=8'h90 -> grant_idx=4 one cycle later.

Source files
------------

// File: rtl/rr_grant_encoder_if.sv
// Bus bundle between the round-robin arbiter and its requesters.
// The release strobe is called release_grant because "release" is a reserved word.
interface rr_grant_encoder_if #(
    parameter int N_REQ = 8,
    parameter int IDX_W = 3
);
    logic [N_REQ-1:0] req;
    logic             release_grant;
    logic             grant_valid;
    logic [IDX_W-1:0] grant_idx;
    logic             timeout;
    logic [IDX_W-1:0] ptr;

    // Requester side: drives requests and release, observes the grant.
    modport master (
        output req,
        output release_grant,
        input  grant_valid,
        input  grant_idx,
        input  timeout,
        input  ptr
    );

    // Arbiter side: samples requests and release, drives the grant.
    modport slave (
        input  req,
        input  release_grant,
        output grant_valid,
        output grant_idx,
        output timeout,
        output ptr
    );
endinterface

// File: rtl/rr_grant_encoder.sv
// 8-requester round-robin arbiter producing a binary grant index for the
// downstream 3-to-8 decoder, with grant hold/release, direct handoff between
// owners and a hold-timeout watchdog. All outputs come straight from flops.
module rr_grant_encoder #(
    parameter int N_REQ    = 8,
    parameter int IDX_W    = 3,   // must equal log2(N_REQ)
    parameter int MAX_HOLD = 15   // 0 disables the watchdog
) (
    input  logic                clk,
    input  logic                rst,
    rr_grant_encoder_if.slave   bus
);

    // hold_cnt needs at least one bit even when the watchdog is disabled.
    localparam int HC_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]      state_q,       state_d;
    logic            grant_valid_q, grant_valid_d;
    logic [IDX_W-1:0] grant_idx_q,  grant_idx_d;
    logic [IDX_W-1:0] ptr_q,        ptr_d;
    logic            timeout_q,     timeout_d;
    logic [HC_W-1:0] hold_cnt_q,    hold_cnt_d;

    logic             idle_found;
    logic [IDX_W-1:0] idle_winner;
    logic             hand_found;
    logic [IDX_W-1:0] hand_winner;
    logic [IDX_W-1:0] next_start;
    logic [N_REQ-1:0] masked_req;
    logic             owner_drop;
    logic             watchdog_hit;
    logic             end_grant;

    // Ascending search from 'start', wrapping at the top; first set bit wins.
    // The index sum wraps naturally because N_REQ is 2**IDX_W.
    function automatic logic [IDX_W:0] rr_search(input logic [N_REQ-1:0] vec,
                                                 input logic [IDX_W-1:0] start);
        logic             found;
        logic [IDX_W-1:0] win;
        logic [IDX_W-1:0] idx;
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = start + IDX_W'(i);
            if (!found && vec[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        return {found, win};
    endfunction

    // Candidate winners for both the idle search and the end-of-grant handoff,
    // where the outgoing owner is masked so it cannot immediately re-win.
    always_comb begin
        next_start   = grant_idx_q + 1'b1;
        masked_req   = bus.req & ~(N_REQ'(1) << grant_idx_q);
        {idle_found, idle_winner} = rr_search(bus.req, ptr_q);
        {hand_found, hand_winner} = rr_search(masked_req, next_start);
        owner_drop   = !bus.req[grant_idx_q];
        watchdog_hit = (MAX_HOLD != 0) && (hold_cnt_q == HC_W'(MAX_HOLD - 1));
        end_grant    = bus.release_grant || owner_drop || watchdog_hit;
    end

    // Next-state logic for the IDLE/GRANT controller and all registered outputs.
    always_comb begin
        state_d       = state_q;
        grant_valid_d = grant_valid_q;
        grant_idx_d   = grant_idx_q;
        ptr_d         = ptr_q;
        timeout_d     = 1'b0;
        hold_cnt_d    = hold_cnt_q;
        case (state_q)
            IDLE: begin
                if (idle_found) begin
                    state_d       = GRANT;
                    grant_valid_d = 1'b1;
                    grant_idx_d   = idle_winner;
                    hold_cnt_d    = '0;
                end
            end
            GRANT: begin
                if (!end_grant) begin
                    if (hold_cnt_q != {HC_W{1'b1}}) begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end else begin
                    ptr_d      = next_start;
                    timeout_d  = watchdog_hit && !bus.release_grant && !owner_drop;
                    hold_cnt_d = '0;
                    if (hand_found) begin
                        grant_idx_d = hand_winner;
                    end else begin
                        state_d       = IDLE;
                        grant_valid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d       = IDLE;
                grant_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset overriding everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_valid_q <= 1'b0;
            grant_idx_q   <= '0;
            ptr_q         <= '0;
            timeout_q     <= 1'b0;
            hold_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            grant_valid_q <= grant_valid_d;
            grant_idx_q   <= grant_idx_d;
            ptr_q         <= ptr_d;
            timeout_q     <= timeout_d;
            hold_cnt_q    <= hold_cnt_d;
        end
    end

    assign bus.grant_valid = grant_valid_q;
    assign bus.grant_idx   = grant_idx_q;
    assign bus.ptr         = ptr_q;
    assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_rr_grant_encoder.sv
// Directed testbench for rr_grant_encoder: a behavioural reference model pushes
// the expected outputs for every driven cycle into a queue, and each queued
// entry is popped and compared one clock later; key scenario points are also
// checked against hand-derived constants.
module tb_rr_grant_encoder;

    localparam int MAX_HOLD = 15;

    typedef struct {
        string      tag;
        logic       gv;
        logic [2:0] idx;
        logic       to;
        logic [2:0] ptr;
    } exp_t;

    logic clk;
    logic rst;
    int   testsRun;
    int   testsFailed;
    exp_t scoreboard[$];

    // reference model state
    logic       mGv;
    logic [2:0] mIdx;
    logic [2:0] mPtr;
    logic       mTo;
    int         mHold;

    rr_grant_encoder_if #(.N_REQ(8), .IDX_W(3)) bus ();

    rr_grant_encoder #(.N_REQ(8), .IDX_W(3), .MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // first set bit at or after 'start', wrapping; -1 if none
    function automatic int rrFind(input logic [7:0] v, input int start);
        for (int j = 0; j < 8; j++) begin
            if (v[(start + j) % 8]) return (start + j) % 8;
        end
        return -1;
    endfunction

    // advance the reference model by one clock edge with the given inputs
    task automatic modelStep(input logic [7:0] r, input logic rl, input logic rs);
        int  w;
        bit  drop;
        bit  wd;
        logic [7:0] m;
        if (rs) begin
            mGv = 0; mIdx = 0; mPtr = 0; mTo = 0; mHold = 0;
        end else if (!mGv) begin
            mTo = 0;
            w = rrFind(r, int'(mPtr));
            if (w >= 0) begin
                mGv = 1; mIdx = 3'(w); mHold = 0;
            end
        end else begin
            drop = !r[mIdx];
            wd   = (MAX_HOLD != 0) && (mHold == MAX_HOLD - 1);
            if (!(rl || drop || wd)) begin
                mTo = 0;
                if (mHold < MAX_HOLD) mHold++;
            end else begin
                mTo  = wd && !rl && !drop;
                mPtr = 3'((int'(mIdx) + 1) % 8);
                m    = r;
                m[mIdx] = 1'b0;
                w = rrFind(m, int'(mPtr));
                mHold = 0;
                if (w >= 0) mIdx = 3'(w);
                else        mGv = 0;
            end
        end
    endtask

    // compare one value and count the result
    task automatic checkValue(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        testsRun++;
        assert (actual === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, actual, expected);
        end
    endtask

    // pop the oldest expectation and compare every output against it
    task automatic checkOutput();
        exp_t e;
        if (scoreboard.size() == 0) begin
            testsRun++;
            testsFailed++;
            $error("[TB] FAIL scoreboard_empty: observed 0 entries expected 1");
            return;
        end
        e = scoreboard.pop_front();
        checkValue({e.tag, "_gv"},  {7'd0, bus.grant_valid}, {7'd0, e.gv});
        checkValue({e.tag, "_idx"}, {5'd0, bus.grant_idx},   {5'd0, e.idx});
        checkValue({e.tag, "_to"},  {7'd0, bus.timeout},     {7'd0, e.to});
        checkValue({e.tag, "_ptr"}, {5'd0, bus.ptr},         {5'd0, e.ptr});
    endtask

    // drive one cycle of inputs, queue the model's prediction, clock, compare
    task automatic applyStimulus(input logic [7:0] r, input logic rl, input logic rs, input string tag);
        exp_t e;
        bus.req           = r;
        bus.release_grant = rl;
        rst               = rs;
        modelStep(r, rl, rs);
        e.tag = tag; e.gv = mGv; e.idx = mIdx; e.to = mTo; e.ptr = mPtr;
        scoreboard.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        int hiCount;
        testsRun    = 0;
        testsFailed = 0;
        bus.req           = '0;
        bus.release_grant = 1'b0;
        rst               = 1'b1;
        mGv = 0; mIdx = 0; mPtr = 0; mTo = 0; mHold = 0;
        @(posedge clk);
        #1;

        // reset state
        applyStimulus(8'h00, 1'b0, 1'b1, "reset");
        checkValue("reset_gv", {7'd0, bus.grant_valid}, 8'd0);
        applyStimulus(8'h00, 1'b1, 1'b0, "idle_release_ignored");

        // single requester, then release with req dropped
        applyStimulus(8'b0000_0100, 1'b0, 1'b0, "single_req");
        checkValue("single_req_idx", {5'd0, bus.grant_idx}, 8'd2);
        applyStimulus(8'h00, 1'b1, 1'b0, "single_release");
        checkValue("single_release_gv", {7'd0, bus.grant_valid}, 8'd0);
        checkValue("single_release_ptr", {5'd0, bus.ptr}, 8'd3);

        // full rotation with continuous handoff
        applyStimulus(8'h00, 1'b0, 1'b1, "reset2");
        applyStimulus(8'hFF, 1'b0, 1'b0, "rot_start");
        checkValue("rot_start_idx", {5'd0, bus.grant_idx}, 8'd0);
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(8'hFF, 1'b1, 1'b0, "rot");
            checkValue("rot_gv", {7'd0, bus.grant_valid}, 8'd1);
            checkValue("rot_idx", {5'd0, bus.grant_idx}, 8'(k % 8));
        end
        applyStimulus(8'h00, 1'b1, 1'b0, "rot_end");

        // wrap-around: get ptr to 6 via owner 5, then 6 -> 0 -> 6
        applyStimulus(8'b0010_0000, 1'b0, 1'b0, "wrap_own5");
        applyStimulus(8'h00, 1'b1, 1'b0, "wrap_rel5");
        checkValue("wrap_ptr6", {5'd0, bus.ptr}, 8'd6);
        applyStimulus(8'b0100_0001, 1'b0, 1'b0, "wrap_g6");
        checkValue("wrap_g6_idx", {5'd0, bus.grant_idx}, 8'd6);
        applyStimulus(8'b0100_0001, 1'b1, 1'b0, "wrap_g0");
        checkValue("wrap_g0_idx", {5'd0, bus.grant_idx}, 8'd0);
        applyStimulus(8'b0100_0001, 1'b1, 1'b0, "wrap_g6b");
        checkValue("wrap_g6b_idx", {5'd0, bus.grant_idx}, 8'd6);
        applyStimulus(8'h00, 1'b1, 1'b0, "wrap_end");

        // watchdog: owner 3 holds with no release
        applyStimulus(8'b0000_1000, 1'b0, 1'b0, "wd_grant");
        hiCount = bus.grant_valid ? 1 : 0;
        for (int k = 0; k < 14; k++) begin
            applyStimulus(8'b0000_1000, 1'b0, 1'b0, "wd_hold");
            if (bus.grant_valid) hiCount++;
        end
        checkValue("wd_hi_cycles", 8'(hiCount), 8'd15);
        applyStimulus(8'b0000_1000, 1'b0, 1'b0, "wd_fire");
        checkValue("wd_fire_gv", {7'd0, bus.grant_valid}, 8'd0);
        checkValue("wd_fire_to", {7'd0, bus.timeout}, 8'd1);
        applyStimulus(8'b0000_1000, 1'b0, 1'b0, "wd_regrant");
        checkValue("wd_regrant_idx", {5'd0, bus.grant_idx}, 8'd3);
        checkValue("wd_regrant_to", {7'd0, bus.timeout}, 8'd0);

        // owner drop hands off without a timeout
        applyStimulus(8'h00, 1'b1, 1'b0, "drop_clear");
        applyStimulus(8'b0010_0000, 1'b0, 1'b0, "drop_own5");
        applyStimulus(8'b0010_0010, 1'b0, 1'b0, "drop_hold");
        applyStimulus(8'b0000_0010, 1'b0, 1'b0, "drop_handoff");
        checkValue("drop_idx", {5'd0, bus.grant_idx}, 8'd1);
        checkValue("drop_to", {7'd0, bus.timeout}, 8'd0);

        // release on the watchdog cycle counts as a normal release
        for (int k = 0; k < 14; k++) begin
            applyStimulus(8'b0000_0010, 1'b0, 1'b0, "wdrel_hold");
        end
        applyStimulus(8'b0000_0010, 1'b1, 1'b0, "wdrel_fire");
        checkValue("wdrel_gv", {7'd0, bus.grant_valid}, 8'd0);
        checkValue("wdrel_to", {7'd0, bus.timeout}, 8'd0);

        // reset in the middle of a grant
        applyStimulus(8'b0001_0000, 1'b0, 1'b0, "rst_own4");
        checkValue("rst_own4_idx", {5'd0, bus.grant_idx}, 8'd4);
        applyStimulus(8'b0001_0000, 1'b0, 1'b1, "rst_mid");
        checkValue("rst_mid_gv", {7'd0, bus.grant_valid}, 8'd0);
        checkValue("rst_mid_ptr", {5'd0, bus.ptr}, 8'd0);
        applyStimulus(8'h90, 1'b0, 1'b0, "rst_after");
        checkValue("rst_after_idx", {5'd0, bus.grant_idx}, 8'd4);

        // random tail cross-checked against the model
        for (int k = 0; k < 60; k++) begin
            applyStimulus(8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 29) == 0), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
